restriction_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives a single-output combinational (or fixed-latency pipelined) logic function over every point of a restricted input subspace. The subspace has chosen variables held constant, and the rest enumerated. For each sweep the block collects the onset count, a CRC-16 signature of the output stream and the first onset point. It sits between the benchmark harness and any N_IN-input/1-output function block, so original and restricted functions can be compared by signature and count without a software model.

---
 rtl/restriction_sweep_ctrl.sv | 159 +++++++++++++++
 tb/tb_restriction_sweep_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/restriction_sweep_ctrl.sv
// Sweeps a 1-output function over every point of a masked input subspace and
// collects onset count, CRC-16 signature and first onset point per sweep.
//
// state   | meaning
// S_IDLE  | waiting for start; results of last sweep held
// S_RUN   | issuing one enumerated vector per cycle
// S_DRAIN | last vector issued, waiting LAT cycles for its f_i
// S_DONE  | one-cycle done pulse, results final
module restriction_sweep_ctrl #(
    parameter int N_IN = 14,
    parameter int LAT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [N_IN-1:0] mask,
    input  logic [N_IN-1:0] fixed_val,
    output logic [N_IN-1:0] vec_o,
    input  logic            f_i,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   onset_count,
    output logic [15:0]     signature,
    output logic [N_IN-1:0] first_one,
    output logic            first_one_valid
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [N_IN-1:0] ONE = N_IN'(1);

    state_t          state;
    logic [N_IN-1:0] mask_l;
    logic [N_IN-1:0] fixed_l;
    logic [N_IN-1:0] cnt;
    logic [N_IN-1:0] cnt_next;
    logic [2:0]      drain_cnt;
    logic            flush;
    logic            al_valid;
    logic [N_IN-1:0] al_vec;
    logic            fb;

    // Forcing masked bits to 1 makes the carry ripple straight through them.
    assign cnt_next = ((cnt | mask_l) + ONE) & ~mask_l;
    assign flush    = abort && (state == S_RUN || state == S_DRAIN);
    assign fb       = signature[15] ^ f_i;

    generate
        if (LAT == 0) begin : g_nolat
            assign al_valid = (state == S_RUN);
            assign al_vec   = vec_o;
        end else begin : g_lat
            logic [LAT-1:0]  pv;
            logic [N_IN-1:0] pvec [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                    for (int i = 0; i < LAT; i++) pvec[i] <= '0;
                end else if (flush) begin
                    pv <= '0;
                end else begin
                    pv[0]   <= (state == S_RUN);
                    pvec[0] <= vec_o;
                    for (int i = 1; i < LAT; i++) begin
                        pv[i]   <= pv[i-1];
                        pvec[i] <= pvec[i-1];
                    end
                end
            end

            assign al_valid = pv[LAT-1];
            assign al_vec   = pvec[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            mask_l          <= '0;
            fixed_l         <= '0;
            cnt             <= '0;
            drain_cnt       <= '0;
            vec_o           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            onset_count     <= '0;
            signature       <= 16'hFFFF;
            first_one       <= '0;
            first_one_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state           <= S_RUN;
                        busy            <= 1'b1;
                        mask_l          <= mask;
                        fixed_l         <= fixed_val;
                        cnt             <= '0;
                        vec_o           <= fixed_val & mask;
                        onset_count     <= '0;
                        signature       <= 16'hFFFF;
                        first_one       <= '0;
                        first_one_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt_next == '0) begin
                        if (LAT > 0) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 3'(LAT - 1);
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt   <= cnt_next;
                        vec_o <= cnt_next | (fixed_l & mask_l);
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (drain_cnt == 3'd0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (al_valid && !flush) begin
                onset_count <= onset_count + {{N_IN{1'b0}}, f_i};
                signature   <= {signature[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                if (f_i && !first_one_valid) begin
                    first_one       <= al_vec;
                    first_one_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_restriction_sweep_ctrl.sv
// Directed bench for restriction_sweep_ctrl: one LAT=0 instance with selectable
// combinational functions and one LAT=2 instance driven by a 2-stage function.
module tb_restriction_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start2 = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] mask = '0;
    logic [13:0] fixed_val = '0;

    logic [13:0] vec0, vec2, fo0, fo2;
    logic        busy0, busy2, done0, done2, fov0, fov2;
    logic [14:0] onset0, onset2;
    logic [15:0] sig0, sig2;
    logic        f0, f2;
    logic        d1 = 1'b0, d2 = 1'b0;
    int          mode = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        f0 = 1'b0;
        case (mode)
            0: f0 = vec0[1];
            1: f0 = &vec0;
            default: f0 = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        d1 <= vec2[0] ^ vec2[3];
        d2 <= d1;
    end
    assign f2 = d2;

    restriction_sweep_ctrl #(.N_IN(14), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .mask(mask), .fixed_val(fixed_val), .vec_o(vec0), .f_i(f0),
        .busy(busy0), .done(done0), .onset_count(onset0), .signature(sig0),
        .first_one(fo0), .first_one_valid(fov0)
    );

    restriction_sweep_ctrl #(.N_IN(14), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
        .mask(mask), .fixed_val(fixed_val), .vec_o(vec2), .f_i(f2),
        .busy(busy2), .done(done2), .onset_count(onset2), .signature(sig2),
        .first_one(fo2), .first_one_valid(fov2)
    );

    function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
        logic fb;
        fb = s[15] ^ b;
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a sweep on one instance and follow it until the done pulse.
    task automatic sweep(input bit sel, input logic [13:0] m, input logic [13:0] fv,
                         input int budget, output int dcyc, output int bcyc, output int serr);
        int          npts;
        logic [13:0] ev;
        logic [13:0] cv;
        npts = 1 << $countones(~m);
        @(negedge clk);
        mask = m;
        fixed_val = fv;
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        mask = ~m;
        fixed_val = ~fv;
        dcyc = -1;
        bcyc = 0;
        serr = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            cv = sel ? vec2 : vec0;
            if (sel ? done2 : done0) begin
                dcyc = c;
                break;
            end
            if (sel ? busy2 : busy0) bcyc++;
            ev = (fv & m) | (14'(c - 1) & ~m);
            if (c <= npts && cv !== ev) serr++;
        end
    endtask

    initial begin
        int          dcyc, bcyc, serr, ndone, nbusy;
        logic [15:0] sig_full, sig_zero, sig_t3;
        logic [13:0] v;

        sig_full = 16'hFFFF;
        sig_zero = 16'hFFFF;
        for (int i = 0; i < 16384; i++) begin
            v = 14'(i);
            sig_full = crc_step(sig_full, &v);
            sig_zero = crc_step(sig_zero, 1'b0);
        end
        sig_t3 = 16'hFFFF;
        for (int i = 16'h50; i <= 16'h5F; i++) begin
            v = 14'(i);
            sig_t3 = crc_step(sig_t3, v[0] ^ v[3]);
        end

        #22;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_vec", vec0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_onset", onset0, 0);
        chk("rst_sig", sig0, 16'hFFFF);
        chk("rst_fov", fov0, 0);
        chk("rst_sig_lat2", sig2, 16'hFFFF);

        // single point, everything held constant
        mode = 0;
        sweep(0, 14'h3FFF, 14'h2AAA, 10, dcyc, bcyc, serr);
        chk("t1_done_cyc", dcyc, 2);
        chk("t1_busy_cycles", bcyc, 1);
        chk("t1_vec_seq", serr, 0);
        chk("t1_vec", vec0, 14'h2AAA);
        chk("t1_onset", onset0, 1);
        chk("t1_first_one", fo0, 14'h2AAA);
        chk("t1_fov", fov0, 1);
        chk("t1_sig", sig0, 16'hFFFE);
        @(negedge clk);
        chk("t1_done_one_cycle", done0, 0);

        // full space, AND of all inputs
        mode = 1;
        sweep(0, 14'h0000, 14'h0000, 16500, dcyc, bcyc, serr);
        chk("t2_done_cyc", dcyc, 16385);
        chk("t2_busy_cycles", bcyc, 16384);
        chk("t2_vec_seq", serr, 0);
        chk("t2_onset", onset0, 1);
        chk("t2_first_one", fo0, 14'h3FFF);
        chk("t2_sig", sig0, sig_full);

        // LAT=2 instance, 4 free bits
        sweep(1, 14'h3FF0, 14'h0050, 60, dcyc, bcyc, serr);
        chk("t3_done_cyc", dcyc, 19);
        chk("t3_busy_cycles", bcyc, 18);
        chk("t3_vec_seq", serr, 0);
        chk("t3_vec_hold", vec2, 14'h005F);
        chk("t3_onset", onset2, 8);
        chk("t3_first_one", fo2, 14'h0051);
        chk("t3_fov", fov2, 1);
        chk("t3_sig", sig2, sig_t3);

        // abort in cycle 100 of a full sweep
        @(negedge clk);
        mask = 14'h0000;
        fixed_val = 14'h0000;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        for (int c = 1; c <= 100; c++) @(negedge clk);
        chk("t4_vec_c100", vec0, 14'd99);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy_c101", busy0, 0);
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 20; c++) begin
            if (done0) ndone++;
            if (busy0) nbusy++;
            @(negedge clk);
        end
        chk("t4_no_done", ndone, 0);
        chk("t4_stays_idle", nbusy, 0);
        sweep(0, 14'h0000, 14'h0000, 16500, dcyc, bcyc, serr);
        chk("t4_rerun_done_cyc", dcyc, 16385);
        chk("t4_rerun_onset", onset0, 1);
        chk("t4_rerun_first_one", fo0, 14'h3FFF);
        chk("t4_rerun_sig", sig0, sig_full);

        // start held high through the sweep
        mode = 0;
        @(negedge clk);
        mask = 14'h3FF0;
        fixed_val = 14'h0000;
        start0 = 1'b1;
        @(posedge clk);
        dcyc = -1;
        ndone = 0;
        nbusy = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done0) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
                start0 = 1'b0;
            end
            if (busy0) nbusy++;
        end
        start0 = 1'b0;
        chk("t5_done_cyc", dcyc, 17);
        chk("t5_done_count", ndone, 1);
        chk("t5_busy_cycles", nbusy, 16);
        chk("t5_onset", onset0, 8);

        // start/abort collision in IDLE
        @(negedge clk);
        start0 = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done0) ndone++;
            if (busy0) nbusy++;
        end
        chk("t5_collision_busy", nbusy, 0);
        chk("t5_collision_done", ndone, 0);
        chk("t5_collision_onset_held", onset0, 8);

        // constant-zero function over the full space
        mode = 2;
        sweep(0, 14'h0000, 14'h0000, 16500, dcyc, bcyc, serr);
        chk("t6_done_cyc", dcyc, 16385);
        chk("t6_onset", onset0, 0);
        chk("t6_fov", fov0, 0);
        chk("t6_sig", sig0, sig_zero);

        // asynchronous reset mid-sweep
        mode = 1;
        @(negedge clk);
        mask = 14'h0000;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy0, 0);
        chk("ar_vec", vec0, 0);
        chk("ar_sig", sig0, 16'hFFFF);
        chk("ar_onset", onset0, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("ar_no_done", ndone, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
